xunit_sha256_msched: RTL and testbench

- Versat functional unit that produces the SHA-256 message schedule W[0..63] for one 512-bit block.
- It is the producer side of the compression-round unit's `w` input: it drives the same word stream, one word per cycle, in lock-step.
- It is configured and triggered exactly like the other Versat units: `run` pulse plus a configurable start delay.
- It accepts the 16 block words serially on in0 and emits all 64 schedule words serially on out0.

---
 rtl/sha256_pkg.sv | 27 ++
 rtl/sha256_sigma.sv | 19 +
 rtl/xunit_sha256_msched.sv | 123 ++++++++++++
 tb/tb_xunit_sha256_msched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: sigma rotate/shift amounts,
// word-count constants and the schedule-unit state encoding.
package sha256_pkg;

   localparam int SIG0_ROT_A = 7;
   localparam int SIG0_ROT_B = 18;
   localparam int SIG0_SHR   = 3;
   localparam int SIG1_ROT_A = 17;
   localparam int SIG1_ROT_B = 19;
   localparam int SIG1_SHR   = 10;

   localparam int NUM_IN_WORDS    = 16;
   localparam int NUM_SCHED_WORDS = 64;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DELAY  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_EXPAND = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small sigma: SEL=0 gives sigma0, SEL=1 gives sigma1.
module sha256_sigma #(
   parameter int SEL = 0
) (
   input  logic [31:0] i_x,
   output logic [31:0] o_y
);
   import sha256_pkg::*;

   // Select the rotate/shift triple at elaboration time.
   always_comb begin
      if (SEL == 0) begin
         o_y = rotr32(i_x, SIG0_ROT_A) ^ rotr32(i_x, SIG0_ROT_B) ^ (i_x >> SIG0_SHR);
      end else begin
         o_y = rotr32(i_x, SIG1_ROT_A) ^ rotr32(i_x, SIG1_ROT_B) ^ (i_x >> SIG1_SHR);
      end
   end

endmodule

// File: rtl/xunit_sha256_msched.sv
// Versat unit producing SHA-256 W[0..63], one word per cycle, after run + delay0.
// Optional XUNIT_SHA256_MSCHED_STALL_EN adds a stall input that freezes active progress.
module xunit_sha256_msched #(
   parameter int DELAY_W = 10,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
`ifdef XUNIT_SHA256_MSCHED_STALL_EN
   input  logic               stall,
`endif
   input  logic [DATA_W-1:0]  in0,
   input  logic [DELAY_W-1:0] delay0,
   output logic [DATA_W-1:0]  out0,
   output logic               done
);
   import sha256_pkg::*;

   generate
      if (DATA_W != 32) begin : g_data_w_check
         $error("xunit_sha256_msched: DATA_W must be 32");
      end
   endgenerate

   state_t             r_state;
   logic [DELAY_W-1:0] r_dly;
   logic [5:0]         r_cnt;
   logic [31:0]        r_win [NUM_IN_WORDS];
   logic [DATA_W-1:0]  r_out;
   logic               r_done;

   logic [31:0]        w_s0;
   logic [31:0]        w_s1;
   logic [31:0]        w_new;
   logic [31:0]        w_shift_in;
   logic               w_stall;

`ifdef XUNIT_SHA256_MSCHED_STALL_EN
   assign w_stall = stall;
`else
   assign w_stall = 1'b0;
`endif

   // r_win[15] is W[t-1], r_win[0] is W[t-16].
   sha256_sigma #(.SEL(0)) u_sigma0 (.i_x(r_win[1]),  .o_y(w_s0));
   sha256_sigma #(.SEL(1)) u_sigma1 (.i_x(r_win[14]), .o_y(w_s1));

   assign w_new = w_s1 + r_win[9] + w_s0 + r_win[0];

   // Newest window entry: the input word while loading, the expanded word afterwards.
   always_comb begin
      w_shift_in = 32'h0000_0000;
      if (r_state == ST_LOAD) begin
         w_shift_in = in0;
      end else begin
         w_shift_in = w_new;
      end
   end

   // Sequencer, window shift register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_dly   <= '0;
         r_cnt   <= 6'd0;
         r_out   <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < NUM_IN_WORDS; i++) begin
            r_win[i] <= 32'h0000_0000;
         end
      end else if (run) begin
         r_dly  <= delay0;
         r_cnt  <= 6'd0;
         r_done <= 1'b0;
         if (delay0 == '0) begin
            r_state <= ST_LOAD;
         end else begin
            r_state <= ST_DELAY;
         end
      end else if (!w_stall) begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_IDLE;
            end
            ST_DELAY: begin
               r_dly <= r_dly - DELAY_W'(1);
               if (r_dly <= DELAY_W'(1)) begin
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD, ST_EXPAND: begin
               r_out <= w_shift_in;
               for (int i = 0; i < NUM_IN_WORDS - 1; i++) begin
                  r_win[i] <= r_win[i+1];
               end
               r_win[NUM_IN_WORDS-1] <= w_shift_in;
               if (r_state == ST_LOAD) begin
                  r_cnt <= r_cnt + 6'd1;
                  if (r_cnt == 6'(NUM_IN_WORDS - 1)) begin
                     r_state <= ST_EXPAND;
                  end
               end else if (r_cnt == 6'(NUM_SCHED_WORDS - 1)) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 6'd1;
               end
            end
            ST_DONE: begin
               r_state <= ST_DONE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out0 = r_out;
   assign done = r_done;

endmodule

// File: tb/tb_xunit_sha256_msched.sv
// Self-checking bench for xunit_sha256_msched: scoreboard of reference schedule words.
// Build with XUNIT_SHA256_MSCHED_STALL_EN to exercise the stall port.
module tb_xunit_sha256_msched;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [31:0] in0;
   logic [9:0]  delay0;
   logic [31:0] out0;
   logic        done;
`ifdef XUNIT_SHA256_MSCHED_STALL_EN
   logic        stall;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] blk   [16];
   logic [31:0] ref_w [64];
   logic [31:0] got_w [64];
   logic [31:0] sb_q  [$];

   always #5 clk = ~clk;

   xunit_sha256_msched #(.DELAY_W(10), .DATA_W(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
`ifdef XUNIT_SHA256_MSCHED_STALL_EN
      .stall  (stall),
`endif
      .in0    (in0),
      .delay0 (delay0),
      .out0   (out0),
      .done   (done)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_ref();
      for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         ref_w[t] = ssig1(ref_w[t-2]) + ref_w[t-7] + ssig0(ref_w[t-15]) + ref_w[t-16];
   endtask

   task automatic random_block();
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
   endtask

   // Starts a block at a negedge; returns early (before active cycle abort_at) if abort_at >= 0.
   task automatic run_block(input int d, input int abort_at, input int stall_pct);
      logic [31:0] prev;
      logic [31:0] exp_w;
      int          k;
      build_ref();
      prev   = out0;
      run    = 1'b1;
      delay0 = d[9:0];
      in0    = $urandom;
      @(posedge clk); @(negedge clk);
      run = 1'b0;
      n_tests++;
      if (done !== 1'b0 || out0 !== prev) begin
         n_fail++;
         $display("FAIL run_edge: got out0=%h done=%b expected out0=%h done=0", out0, done, prev);
      end
      for (int i = 0; i < d; i++) begin
         in0 = $urandom;
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (out0 !== prev || done !== 1'b0) begin
            n_fail++;
            $display("FAIL delay_hold[%0d]: got out0=%h done=%b expected out0=%h done=0", i, out0, done, prev);
         end
      end
      k = 0;
      while (k < 64) begin
         if (k == abort_at) return;
`ifdef XUNIT_SHA256_MSCHED_STALL_EN
         if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
            stall = 1'b1;
            in0   = $urandom;
            @(posedge clk); @(negedge clk);
            stall = 1'b0;
            n_tests++;
            if (out0 !== prev || done !== 1'b0) begin
               n_fail++;
               $display("FAIL stall_hold[%0d]: got out0=%h done=%b expected out0=%h done=0", k, out0, done, prev);
            end
            continue;
         end
`endif
         in0 = (k < 16) ? blk[k] : $urandom;
         sb_q.push_back(ref_w[k]);
         @(posedge clk); @(negedge clk);
         exp_w = sb_q.pop_front();
         got_w[k] = out0;
         n_tests++;
         if (out0 !== exp_w) begin
            n_fail++;
            $display("FAIL w[%0d]: got %h expected %h", k, out0, exp_w);
         end
         n_tests++;
         if (done !== (k == 63)) begin
            n_fail++;
            $display("FAIL done_at[%0d]: got %b expected %b", k, done, (k == 63));
         end
         prev = out0;
         k++;
      end
   endtask

   task automatic check_idle_zero(input string name, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         in0 = $urandom | 32'h1;
         @(posedge clk); @(negedge clk);
         n_tests++;
         if (out0 !== 32'h0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s[%0d]: got out0=%h done=%b expected out0=0 done=0", name, i, out0, done);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (out0 !== 32'h0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got out0=%h done=%b expected out0=0 done=0", out0, done);
      end
      check_idle_zero("reset_idle", 3);
   endtask

   task automatic test_abc();
      blk[0] = 32'h6162_6380;
      for (int i = 1; i < 15; i++) blk[i] = 32'h0;
      blk[15] = 32'h0000_0018;
      run_block(0, -1, 0);
      n_tests++;
      if (got_w[16] !== 32'h6162_6380) begin
         n_fail++;
         $display("FAIL abc_w16: got %h expected 61626380", got_w[16]);
      end
      n_tests++;
      if (got_w[17] !== 32'h000F_0000) begin
         n_fail++;
         $display("FAIL abc_w17: got %h expected 000f0000", got_w[17]);
      end
   endtask

   task automatic test_delay();
      random_block();
      run_block(5, -1, 0);
   endtask

   task automatic test_restart();
      random_block();
      run_block(0, 30, 0);
      random_block();
      run_block(0, -1, 0);
   endtask

   task automatic test_back_to_back();
      random_block();
      run_block(0, -1, 0);
      random_block();
      run_block(0, -1, 0);
   endtask

   task automatic test_reset_mid_expand();
      random_block();
      run_block(0, 20, 0);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (out0 !== 32'h0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got out0=%h done=%b expected out0=0 done=0", out0, done);
      end
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check_idle_zero("reset_mid_idle", 5);
   endtask

   task automatic test_run_with_rst();
      rst    = 1'b1;
      run    = 1'b1;
      delay0 = 10'd0;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      check_idle_zero("run_rst", 4);
   endtask

   task automatic test_stall();
      random_block();
      run_block(0, -1, 30);
      random_block();
      run_block(3, -1, 50);
   endtask

   initial begin
      rst    = 1'b1;
      run    = 1'b0;
      in0    = 32'h0;
      delay0 = 10'd0;
`ifdef XUNIT_SHA256_MSCHED_STALL_EN
      stall  = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_abc();
      test_delay();
      test_restart();
      test_back_to_back();
      test_reset_mid_expand();
      test_run_with_rst();
`ifdef XUNIT_SHA256_MSCHED_STALL_EN
      test_stall();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
